// File: rtl/embs_mst_arbiter.sv
// Two-requester read-port arbiter for the PLB master interface.
// Requester 0 (VGA fetch) has fixed priority. A consecutive-grant limit keeps
// requester 1 (DMA/blitter) from starving. The granted command is latched,
// the bus handshake is forwarded, and read data is steered to the owner.
module embs_mst_arbiter #(
  parameter int unsigned MAX_CONSEC = 4,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic        Bus2IP_Clk,
  input  logic        Bus2IP_Reset,
  input  logic        Req0_RdReq,
  input  logic [0:31] Req0_Addr,
  input  logic [0:11] Req0_Length,
  input  logic        Req0_Type,
  output logic        Req0_CmdAck,
  output logic [0:31] Req0_RdD,
  output logic        Req0_Sof_n,
  output logic        Req0_Eof_n,
  output logic        Req0_SrcRdy_n,
  input  logic        Req1_RdReq,
  input  logic [0:31] Req1_Addr,
  input  logic [0:11] Req1_Length,
  input  logic        Req1_Type,
  output logic        Req1_CmdAck,
  output logic [0:31] Req1_RdD,
  output logic        Req1_Sof_n,
  output logic        Req1_Eof_n,
  output logic        Req1_SrcRdy_n,
  output logic        IP2Bus_MstRd_Req,
  output logic [0:31] IP2Bus_Mst_Addr,
  output logic [0:11] IP2Bus_Mst_Length,
  output logic        IP2Bus_Mst_Type,
  input  logic        Bus2IP_Mst_CmdAck,
  input  logic [0:31] Bus2IP_MstRd_d,
  input  logic        Bus2IP_MstRd_sof_n,
  input  logic        Bus2IP_MstRd_eof_n,
  input  logic        Bus2IP_MstRd_src_rdy_n,
  output logic [1:0]  Grant,
  output logic        Busy,
  output logic        Abort
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [3:0]  CONSEC_LIM = 4'(MAX_CONSEC);
  localparam logic [11:0] TIMER_LAST = 12'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        owner_q, owner_d;      // 1 = requester 1 owns the current command
  logic [0:31] addr_q, addr_d;
  logic [0:11] len_q, len_d;
  logic        type_q, type_d;
  logic        mst_req_q, mst_req_d;
  logic        abort_q, abort_d;
  logic [3:0]  consec_q, consec_d;
  logic [11:0] timer_q, timer_d;

  logic        sel1;
  logic        in_cmd, in_data;
  logic        eof_beat;

  // Next-state, arbitration and bookkeeping
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    len_d     = len_q;
    type_d    = type_q;
    mst_req_d = mst_req_q;
    abort_d   = 1'b0;
    consec_d  = consec_q;
    timer_d   = timer_q;
    sel1      = Req1_RdReq && (!Req0_RdReq || (consec_q >= CONSEC_LIM));
    eof_beat  = !Bus2IP_MstRd_eof_n && !Bus2IP_MstRd_src_rdy_n;

    case (state_q)
      S_IDLE: begin
        if (Req0_RdReq || Req1_RdReq) begin
          owner_d   = sel1;
          grant_d   = sel1 ? 2'b10 : 2'b01;
          addr_d    = sel1 ? Req1_Addr : Req0_Addr;
          len_d     = sel1 ? Req1_Length : Req0_Length;
          type_d    = sel1 ? Req1_Type : Req0_Type;
          mst_req_d = 1'b1;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (Bus2IP_Mst_CmdAck) begin
          mst_req_d = 1'b0;
          timer_d   = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        // A valid EOF beat wins over a timeout landing in the same cycle.
        if (eof_beat) begin
          grant_d = '0;
          state_d = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          grant_d = '0;
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      S_DONE: begin
        if (!owner_q && Req1_RdReq) begin
          consec_d = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
        end else begin
          consec_d = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, asynchronously reset
  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      type_q    <= 1'b0;
      mst_req_q <= 1'b0;
      abort_q   <= 1'b0;
      consec_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      type_q    <= type_d;
      mst_req_q <= mst_req_d;
      abort_q   <= abort_d;
      consec_q  <= consec_d;
      timer_q   <= timer_d;
    end
  end

  assign in_cmd  = (state_q == S_CMD);
  assign in_data = (state_q == S_DATA);

  assign IP2Bus_MstRd_Req  = mst_req_q;
  assign IP2Bus_Mst_Addr   = addr_q;
  assign IP2Bus_Mst_Length = len_q;
  assign IP2Bus_Mst_Type   = type_q;
  assign Grant             = grant_q;
  assign Busy              = (state_q != S_IDLE);
  assign Abort             = abort_q;

  // Command acknowledge and read data steered to the owner only
  always_comb begin
    Req0_CmdAck   = in_cmd && grant_q[0] && Bus2IP_Mst_CmdAck;
    Req1_CmdAck   = in_cmd && grant_q[1] && Bus2IP_Mst_CmdAck;
    Req0_RdD      = '0;
    Req0_Sof_n    = 1'b1;
    Req0_Eof_n    = 1'b1;
    Req0_SrcRdy_n = 1'b1;
    Req1_RdD      = '0;
    Req1_Sof_n    = 1'b1;
    Req1_Eof_n    = 1'b1;
    Req1_SrcRdy_n = 1'b1;
    if (in_data && grant_q[0]) begin
      Req0_RdD      = Bus2IP_MstRd_d;
      Req0_Sof_n    = Bus2IP_MstRd_sof_n;
      Req0_Eof_n    = Bus2IP_MstRd_eof_n;
      Req0_SrcRdy_n = Bus2IP_MstRd_src_rdy_n;
    end
    if (in_data && grant_q[1]) begin
      Req1_RdD      = Bus2IP_MstRd_d;
      Req1_Sof_n    = Bus2IP_MstRd_sof_n;
      Req1_Eof_n    = Bus2IP_MstRd_eof_n;
      Req1_SrcRdy_n = Bus2IP_MstRd_src_rdy_n;
    end
  end

endmodule

// File: tb/tb_embs_mst_arbiter.sv
// Bench for embs_mst_arbiter: two instances (long and short timeout) share
// stimulus and are each tracked by a transaction-level model every cycle.
module tb_embs_mst_arbiter;

  localparam int TO0 = 4095;
  localparam int TO1 = 16;
  localparam int MC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd_req [2];
  logic [0:31] r_addr [2];
  logic [0:11] r_len  [2];
  logic        r_type [2];
  logic        b_ack, b_sof, b_eof, b_srdy;
  logic [0:31] b_d;
  bit          hold   [2];

  logic        ack_o   [2][2];
  logic [0:31] rdd_o   [2][2];
  logic        sof_o   [2][2];
  logic        eof_o   [2][2];
  logic        srdy_o  [2][2];
  logic        mreq_o  [2];
  logic [0:31] maddr_o [2];
  logic [0:11] mlen_o  [2];
  logic        mtype_o [2];
  logic [1:0]  grant_o [2];
  logic        busy_o  [2];
  logic        abort_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    embs_mst_arbiter #(.MAX_CONSEC(MC), .TIMEOUT(g == 0 ? TO0 : TO1)) u_dut (
      .Bus2IP_Clk             (clk),
      .Bus2IP_Reset           (rst),
      .Req0_RdReq             (rd_req[0]),
      .Req0_Addr              (r_addr[0]),
      .Req0_Length            (r_len[0]),
      .Req0_Type              (r_type[0]),
      .Req0_CmdAck            (ack_o[g][0]),
      .Req0_RdD               (rdd_o[g][0]),
      .Req0_Sof_n             (sof_o[g][0]),
      .Req0_Eof_n             (eof_o[g][0]),
      .Req0_SrcRdy_n          (srdy_o[g][0]),
      .Req1_RdReq             (rd_req[1]),
      .Req1_Addr              (r_addr[1]),
      .Req1_Length            (r_len[1]),
      .Req1_Type              (r_type[1]),
      .Req1_CmdAck            (ack_o[g][1]),
      .Req1_RdD               (rdd_o[g][1]),
      .Req1_Sof_n             (sof_o[g][1]),
      .Req1_Eof_n             (eof_o[g][1]),
      .Req1_SrcRdy_n          (srdy_o[g][1]),
      .IP2Bus_MstRd_Req       (mreq_o[g]),
      .IP2Bus_Mst_Addr        (maddr_o[g]),
      .IP2Bus_Mst_Length      (mlen_o[g]),
      .IP2Bus_Mst_Type        (mtype_o[g]),
      .Bus2IP_Mst_CmdAck      (b_ack),
      .Bus2IP_MstRd_d         (b_d),
      .Bus2IP_MstRd_sof_n     (b_sof),
      .Bus2IP_MstRd_eof_n     (b_eof),
      .Bus2IP_MstRd_src_rdy_n (b_srdy),
      .Grant                  (grant_o[g]),
      .Busy                   (busy_o[g]),
      .Abort                  (abort_o[g])
    );
  end

  int chk  = 0;
  int errs = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    chk++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Transaction model: who owns the port, how far the transaction has got,
  // how many beats-cycles the burst has lasted, and the req0 win streak.
  localparam int NONE = 0, ASKING = 1, STREAMING = 2, COOLDOWN = 3;
  typedef struct {
    int          phase;
    int          owner;
    int          streak;
    int          age;
    bit          aborted;
    bit [0:31]   a;
    bit [0:11]   l;
    bit          t;
  } mdl_t;

  mdl_t mdl [2];
  mdl_t mdl_nxt [2];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = NONE; r.owner = 0; r.streak = 0; r.age = 0; r.aborted = 0;
    r.a = '0; r.l = '0; r.t = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int to);
    mdl_t r = m;
    int w;
    r.aborted = 0;
    if (m.phase == NONE) begin
      if (rd_req[0] || rd_req[1]) begin
        w = (rd_req[1] && (!rd_req[0] || m.streak >= MC)) ? 1 : 0;
        r.owner = w; r.a = r_addr[w]; r.l = r_len[w]; r.t = r_type[w];
        r.phase = ASKING;
      end
    end else if (m.phase == ASKING) begin
      if (b_ack) begin r.phase = STREAMING; r.age = 0; end
    end else if (m.phase == STREAMING) begin
      if (!b_eof && !b_srdy) r.phase = COOLDOWN;
      else if (m.age + 1 == to) begin r.phase = NONE; r.aborted = 1; end
      else r.age = m.age + 1;
    end else begin
      if (m.owner == 0 && rd_req[1]) r.streak = (m.streak < 15) ? m.streak + 1 : 15;
      else r.streak = 0;
      r.phase = NONE;
    end
    return r;
  endfunction

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    mdl_t m;
    logic [1:0] eg;
    logic [35:0] er, ar;
    bit mine;
    for (int i = 0; i < 2; i++) begin
      m  = mdl[i];
      eg = (m.phase == ASKING || m.phase == STREAMING) ? ((m.owner == 0) ? 2'b01 : 2'b10) : 2'b00;
      check($sformatf("grant[%0d]", i), grant_o[i], eg);
      check($sformatf("busy[%0d]", i), busy_o[i], m.phase != NONE);
      check($sformatf("abort[%0d]", i), abort_o[i], m.aborted);
      check($sformatf("mst_req[%0d]", i), mreq_o[i], m.phase == ASKING);
      check($sformatf("mst_cmd[%0d]", i), {mtype_o[i], mlen_o[i], maddr_o[i]}, {m.t, m.l, m.a});
      for (int n = 0; n < 2; n++) begin
        mine = (m.phase == STREAMING) && (m.owner == n);
        er = {(m.phase == ASKING) && (m.owner == n) && b_ack,
              mine ? b_d : 32'h0, mine ? b_sof : 1'b1, mine ? b_eof : 1'b1, mine ? b_srdy : 1'b1};
        ar = {ack_o[i][n], rdd_o[i][n], sof_o[i][n], eof_o[i][n], srdy_o[i][n]};
        check($sformatf("req%0d_side[%0d]", n, i), ar, er);
      end
      mdl_nxt[i] = mdl_step(m, (i == 0) ? TO0 : TO1);
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) mdl[i] <= rst ? mdl_reset() : mdl_nxt[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    b_ack = 0; b_sof = 1; b_eof = 1; b_srdy = 1; b_d = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    for (int n = 0; n < 2; n++) begin
      rd_req[n] = 0; r_addr[n] = '0; r_len[n] = '0; r_type[n] = 0; hold[n] = 0;
    end
    bus_idle();
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic request(input int n, input logic [0:31] a, input logic [0:11] l, input logic t);
    rd_req[n] = 1; r_addr[n] = a; r_len[n] = l; r_type[n] = t;
  endtask

  // Wait (bounded) for a bus request, acknowledge it, report which requester got CmdAck
  task automatic bus_cmd(output int who);
    int k = 0;
    who = -1;
    while (!(mreq_o[0] || mreq_o[1]) && k < 20) begin tick(); k++; end
    if (!(mreq_o[0] || mreq_o[1])) begin
      check("cmd_wait", mreq_o[0] | mreq_o[1], 1);
      return;
    end
    b_ack = 1;
    #1;
    for (int n = 0; n < 2; n++) if (ack_o[0][n] || ack_o[1][n]) who = n;
    tick();
    b_ack = 0;
    if (who >= 0 && !hold[who]) rd_req[who] = 0;
  endtask

  // Stream nb beats; count those arriving intact at each requester of instance inst
  task automatic burst(input int inst, input int nb, input bit last_eof, output int s0, output int s1);
    s0 = 0; s1 = 0;
    for (int k = 0; k < nb; k++) begin
      b_srdy = 0; b_sof = (k == 0) ? 1'b0 : 1'b1;
      b_eof = (k == nb - 1 && last_eof) ? 1'b0 : 1'b1;
      b_d = 32'hA500_0000 + k;
      #1;
      if (!srdy_o[inst][0] && rdd_o[inst][0] == b_d) s0++;
      if (!srdy_o[inst][1] && rdd_o[inst][1] == b_d) s1++;
      tick();
    end
    bus_idle();
  endtask

  initial begin
    int who, s0, s1, cnt, bad;
    int order [10];
    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // 1: single requester 0 burst
    do_reset();
    request(0, 32'h100, 12'd800, 1'b1);
    check("t1_req_before_edge", mreq_o[0], 0);
    tick();
    check("t1_req_rise", mreq_o[0], 1);
    check("t1_addr", maddr_o[0], 32'h100);
    check("t1_len", mlen_o[0], 800);
    bus_cmd(who);
    check("t1_owner", who, 0);
    burst(0, 200, 1, s0, s1);
    check("t1_beats_req0", s0, 200);
    check("t1_beats_req1", s1, 0);
    check("t1_grant_done", grant_o[0], 2'b00);
    tick();
    check("t1_idle", busy_o[0], 0);

    // 2: both held high, fairness every MAX_CONSEC grants
    do_reset();
    hold[0] = 1; hold[1] = 1;
    request(0, 32'h1000, 12'd8, 1'b1);
    request(1, 32'h2000, 12'd8, 1'b1);
    for (int t = 0; t < 10; t++) begin
      bus_cmd(who);
      order[t] = who;
      burst(0, 2, 1, s0, s1);
    end
    rd_req[0] = 0; rd_req[1] = 0;
    for (int t = 0; t < 10; t++) check($sformatf("t2_order%0d", t), order[t], exp_order[t]);
    tick(); tick();

    // 3: req1 alone, req0 arriving mid-burst waits for the IDLE after DONE
    do_reset();
    request(1, 32'h200, 12'd16, 1'b1);
    bus_cmd(who);
    check("t3_owner1", who, 1);
    request(0, 32'h300, 12'd4, 1'b0);
    burst(0, 4, 1, s0, s1);
    check("t3_beats_req1", s1, 4);
    check("t3_beats_req0", s0, 0);
    check("t3_done_grant", grant_o[0], 2'b00);
    check("t3_done_busy", busy_o[0], 1);
    tick();
    check("t3_idle_busy", busy_o[0], 0);
    tick();
    check("t3_grant0", grant_o[0], 2'b01);
    check("t3_addr0", maddr_o[0], 32'h300);
    bus_cmd(who);
    burst(0, 1, 1, s0, s1);
    tick(); tick();

    // 4: no EOF -> timeout abort on the short-timeout instance, then normal service
    do_reset();
    request(0, 32'h400, 12'd16, 1'b1);
    bus_cmd(who);
    b_srdy = 0; b_eof = 1; b_d = 32'h5555_AAAA;
    cnt = 0;
    while (!abort_o[1] && cnt < 40) begin tick(); cnt++; end
    check("t4_abort_cycles", cnt, 16);
    check("t4_abort_grant", grant_o[1], 2'b00);
    check("t4_abort_busy", busy_o[1], 0);
    bus_idle();
    tick();
    check("t4_abort_pulse", abort_o[1], 0);
    request(0, 32'h480, 12'd8, 1'b0);
    bus_cmd(who);
    check("t4_next_owner", who, 0);
    burst(1, 2, 1, s0, s1);
    check("t4_next_beats", s0, 2);
    tick(); tick();

    // 5: asynchronous reset mid-burst
    do_reset();
    request(0, 32'h500, 12'd800, 1'b1);
    bus_cmd(who);
    burst(0, 50, 0, s0, s1);
    b_srdy = 0; b_d = 32'hDEAD_BEEF;
    #2;
    rst = 1;
    #1;
    check("t5_grant", grant_o[0], 2'b00);
    check("t5_busy", busy_o[0], 0);
    check("t5_mreq", mreq_o[0], 0);
    check("t5_addr", maddr_o[0], 0);
    check("t5_req0_out", {ack_o[0][0], rdd_o[0][0], sof_o[0][0], eof_o[0][0], srdy_o[0][0]}, 36'h0_0000_0007);
    tick();
    rst = 0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      b_ack = (k % 2 == 1); b_srdy = 0; b_d = k;
      #1;
      for (int n = 0; n < 2; n++) if (ack_o[0][n] || !srdy_o[0][n]) bad++;
      tick();
    end
    check("t5_quiet", bad, 0);
    bus_idle();

    // 6: EOF without SrcRdy does not end the burst
    do_reset();
    request(1, 32'h600, 12'd8, 1'b1);
    bus_cmd(who);
    b_srdy = 0; b_sof = 0; b_eof = 1; b_d = 32'h1;
    tick();
    b_srdy = 1; b_sof = 1; b_eof = 0; b_d = 32'h2;
    tick();
    check("t6_still_data", grant_o[0], 2'b10);
    b_srdy = 0; b_eof = 0; b_d = 32'h3;
    tick();
    check("t6_done_grant", grant_o[0], 2'b00);
    check("t6_done_busy", busy_o[0], 1);
    bus_idle();
    tick();
    check("t6_idle", busy_o[0], 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
